// File: rtl/tcp_port_table_mc_if.sv
// Valid/ready/data stream used on every request and response port of tcp_port_table_mc.
// Handshake: a transfer occurs on the rising clock edge where valid and ready are both high; the master holds valid and data stable until ready.
interface tcp_port_table_mc_if #(
    parameter int W = 16
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport m (output valid, output data, input ready);
    modport s (input valid, input data, output ready);
endinterface

// File: rtl/tcp_port_table_mc.sv
// TCP listen-port table: range/collision-checked listen path, N_LUP replicated lookup RAMs, post-reset clear sweep.
// Optional owner-checked close path is enabled by defining TCP_PORT_CLOSE_EN.
module tcp_port_table_mc #(
    parameter int          PORT_ORDER = 10,
    parameter logic [15:0] PORT_OFFS  = 16'd5000,
    parameter int          RSID_BITS  = 14,
    parameter int          ROUTE_BITS = 14,
    parameter int          N_LUP      = 1,
    parameter int          VFID_BITS  = 4
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    tcp_port_table_mc_if.s              s_listen_req,
    tcp_port_table_mc_if.m              m_listen_req,
    tcp_port_table_mc_if.s              s_listen_rsp,
    tcp_port_table_mc_if.m              m_listen_rsp,
    tcp_port_table_mc_if.s              s_close_req,
    tcp_port_table_mc_if.m              m_close_rsp,
    input  logic [N_LUP*PORT_ORDER-1:0] port_addr,
    output logic [N_LUP*RSID_BITS-1:0]  rsid_out,
    output logic [N_LUP*ROUTE_BITS-1:0] route_id_out,
    output logic [N_LUP-1:0]            entry_vld_out,
    output logic                        init_done,
    output logic [3:0]                  dbg_state
);
    localparam int DEPTH = 1 << PORT_ORDER;
    localparam int EW    = 1 + RSID_BITS + ROUTE_BITS;
    localparam int NREP  = N_LUP + 1;

    typedef enum logic [3:0] {
        ST_INIT, ST_IDLE, ST_LUP, ST_WAIT, ST_CHECK, ST_SEND, ST_RSP_WAIT, ST_RSP_COL
`ifdef TCP_PORT_CLOSE_EN
        , ST_CLOSE_LUP, ST_CLOSE_WAIT, ST_CLOSE_CHK, ST_CLOSE_RSP
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [PORT_ORDER-1:0]   init_cnt_q, init_cnt_d;
    logic [15:0]             port_q, port_d;
    logic [RSID_BITS-1:0]    rsid_q, rsid_d;
    logic [ROUTE_BITS-1:0]   route_q, route_d;
    logic [PORT_ORDER-1:0]   idx_q, idx_d;
    logic                    in_range_q, in_range_d;
    logic                    wr_pend_q, wr_pend_d;
    logic                    close_ok_q, close_ok_d;

    logic                    wr_en;
    logic [PORT_ORDER-1:0]   wr_idx;
    logic [EW-1:0]           wr_data;
    logic [PORT_ORDER-1:0]   rd_addr [NREP];
    logic [EW-1:0]           rd_data [NREP];
    logic [EW-1:0]           ctrl_rd;

    logic                    listen_req_ready, close_req_ready, fwd_valid, engine_ready;
    logic                    lrsp_valid, close_rsp_valid;
    logic [VFID_BITS:0]      lrsp_data;
    logic [16:0]             close_rsp_data;

    logic [15:0]             l_port;
    logic [RSID_BITS-1:0]    l_rsid;
    logic [ROUTE_BITS-1:0]   l_route;
    logic [VFID_BITS-1:0]    vfid;

    function automatic logic port_in_range(input logic [15:0] p);
        logic [15:0] off;
        off = p - PORT_OFFS;
        return (p >= PORT_OFFS) && ({1'b0, off} < 17'(DEPTH));
    endfunction

    assign l_port  = s_listen_req.data[RSID_BITS+ROUTE_BITS +: 16];
    assign l_rsid  = s_listen_req.data[ROUTE_BITS +: RSID_BITS];
    assign l_route = s_listen_req.data[ROUTE_BITS-1:0];
    assign vfid    = rsid_q[RSID_BITS-1 -: VFID_BITS];
    assign ctrl_rd = rd_data[N_LUP];

`ifdef TCP_PORT_CLOSE_EN
    logic [15:0]          c_port;
    logic [RSID_BITS-1:0] c_rsid;
    assign c_port = s_close_req.data[RSID_BITS +: 16];
    assign c_rsid = s_close_req.data[RSID_BITS-1:0];
`else
    logic unused_close;
    assign unused_close = ^{s_close_req.valid, s_close_req.data, m_close_rsp.ready, ctrl_rd[EW-2:0]};
`endif

    always_comb begin
        state_d          = state_q;
        init_cnt_d       = init_cnt_q;
        port_d           = port_q;
        rsid_d           = rsid_q;
        route_d          = route_q;
        idx_d            = idx_q;
        in_range_d       = in_range_q;
        wr_pend_d        = 1'b0;
        close_ok_d       = close_ok_q;
        listen_req_ready = 1'b0;
        close_req_ready  = 1'b0;
        fwd_valid        = 1'b0;
        engine_ready     = 1'b0;
        lrsp_valid       = 1'b0;
        lrsp_data        = '0;
        close_rsp_valid  = 1'b0;
        close_rsp_data   = '0;
        // A successful engine open lands in the table one cycle after its handshake.
        wr_en            = wr_pend_q;
        wr_idx           = idx_q;
        wr_data          = {1'b1, rsid_q, route_q};
        case (state_q)
            ST_INIT: begin
                wr_en      = 1'b1;
                wr_idx     = init_cnt_q;
                wr_data    = '0;
                init_cnt_d = init_cnt_q + 1'b1;
                if (init_cnt_q == PORT_ORDER'(DEPTH - 1)) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (s_listen_req.valid) begin
                    listen_req_ready = 1'b1;
                    port_d     = l_port;
                    rsid_d     = l_rsid;
                    route_d    = l_route;
                    idx_d      = PORT_ORDER'(l_port - PORT_OFFS);
                    in_range_d = port_in_range(l_port);
                    state_d    = port_in_range(l_port) ? ST_LUP : ST_RSP_COL;
                end
`ifdef TCP_PORT_CLOSE_EN
                else if (s_close_req.valid) begin
                    close_req_ready = 1'b1;
                    port_d     = c_port;
                    rsid_d     = c_rsid;
                    idx_d      = PORT_ORDER'(c_port - PORT_OFFS);
                    in_range_d = port_in_range(c_port);
                    state_d    = ST_CLOSE_LUP;
                end
`endif
            end
            ST_LUP:   state_d = ST_WAIT;
            ST_WAIT:  state_d = ST_CHECK;
            ST_CHECK: state_d = ctrl_rd[EW-1] ? ST_RSP_COL : ST_SEND;
            ST_SEND: begin
                fwd_valid = 1'b1;
                if (m_listen_req.ready) state_d = ST_RSP_WAIT;
            end
            ST_RSP_WAIT: begin
                engine_ready = m_listen_rsp.ready;
                lrsp_valid   = s_listen_rsp.valid;
                lrsp_data    = {vfid, s_listen_rsp.data[0]};
                if (s_listen_rsp.valid && m_listen_rsp.ready) begin
                    wr_pend_d = s_listen_rsp.data[0];
                    state_d   = ST_IDLE;
                end
            end
            ST_RSP_COL: begin
                lrsp_valid = 1'b1;
                lrsp_data  = {vfid, 1'b0};
                if (m_listen_rsp.ready) state_d = ST_IDLE;
            end
`ifdef TCP_PORT_CLOSE_EN
            ST_CLOSE_LUP:  state_d = ST_CLOSE_WAIT;
            ST_CLOSE_WAIT: state_d = ST_CLOSE_CHK;
            ST_CLOSE_CHK: begin
                close_ok_d = in_range_q && ctrl_rd[EW-1] && (ctrl_rd[ROUTE_BITS +: RSID_BITS] == rsid_q);
                if (close_ok_d) begin
                    wr_en   = 1'b1;
                    wr_data = '0;
                end
                state_d = ST_CLOSE_RSP;
            end
            ST_CLOSE_RSP: begin
                close_rsp_valid = 1'b1;
                close_rsp_data  = {port_q, close_ok_q};
                if (m_close_rsp.ready) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
            port_q     <= '0;
            rsid_q     <= '0;
            route_q    <= '0;
            idx_q      <= '0;
            in_range_q <= 1'b0;
            wr_pend_q  <= 1'b0;
            close_ok_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            port_q     <= port_d;
            rsid_q     <= rsid_d;
            route_q    <= route_d;
            idx_q      <= idx_d;
            in_range_q <= in_range_d;
            wr_pend_q  <= wr_pend_d;
            close_ok_q <= close_ok_d;
        end
    end

    assign s_listen_req.ready = listen_req_ready;
    assign s_close_req.ready  = close_req_ready;
    assign m_listen_req.valid = fwd_valid;
    assign m_listen_req.data  = port_q;
    assign s_listen_rsp.ready = engine_ready;
    assign m_listen_rsp.valid = lrsp_valid;
    assign m_listen_rsp.data  = lrsp_data;
    assign m_close_rsp.valid  = close_rsp_valid;
    assign m_close_rsp.data   = close_rsp_data;
    assign init_done          = (state_q != ST_INIT);
    assign dbg_state          = state_q;

    // Replica N_LUP serves the control FSM; the others serve the lookup lanes.
    always_comb begin
        for (int i = 0; i < N_LUP; i++) rd_addr[i] = port_addr[i*PORT_ORDER +: PORT_ORDER];
        rd_addr[N_LUP] = idx_q;
    end

    for (genvar g = 0; g < NREP; g++) begin : g_rep
        logic [EW-1:0]         ram_q [DEPTH];
        logic [PORT_ORDER-1:0] rd_addr_q;
        logic [EW-1:0]         rd_data_q;
        always_ff @(posedge aclk) begin
            if (wr_en) ram_q[wr_idx] <= wr_data;
            rd_addr_q <= rd_addr[g];
            rd_data_q <= ram_q[rd_addr_q];
        end
        assign rd_data[g] = rd_data_q;
    end

    always_comb begin
        for (int i = 0; i < N_LUP; i++) begin
            entry_vld_out[i]                         = rd_data[i][EW-1];
            rsid_out[i*RSID_BITS +: RSID_BITS]       = rd_data[i][ROUTE_BITS +: RSID_BITS];
            route_id_out[i*ROUTE_BITS +: ROUTE_BITS] = rd_data[i][ROUTE_BITS-1:0];
        end
    end
endmodule

// File: tb/tb_tcp_port_table_mc.sv
// Directed bench for tcp_port_table_mc with PORT_ORDER=4 (16 entries) and two lookup lanes.
module tb_tcp_port_table_mc;
    localparam int PO = 4;
    localparam int RB = 14;
    localparam int TB = 14;
    localparam int NL = 2;
    localparam int VB = 4;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    tcp_port_table_mc_if #(.W(16+RB+TB)) s_listen_req ();
    tcp_port_table_mc_if #(.W(16))       m_listen_req ();
    tcp_port_table_mc_if #(.W(1))        s_listen_rsp ();
    tcp_port_table_mc_if #(.W(VB+1))     m_listen_rsp ();
    tcp_port_table_mc_if #(.W(16+RB))    s_close_req ();
    tcp_port_table_mc_if #(.W(17))       m_close_rsp ();

    logic [NL*PO-1:0] port_addr;
    logic [NL*RB-1:0] rsid_out;
    logic [NL*TB-1:0] route_id_out;
    logic [NL-1:0]    entry_vld_out;
    logic             init_done;
    logic [3:0]       dbg_state;

    tcp_port_table_mc #(
        .PORT_ORDER(PO), .PORT_OFFS(16'd5000), .RSID_BITS(RB),
        .ROUTE_BITS(TB), .N_LUP(NL), .VFID_BITS(VB)
    ) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_listen_req(s_listen_req), .m_listen_req(m_listen_req),
        .s_listen_rsp(s_listen_rsp), .m_listen_rsp(m_listen_rsp),
        .s_close_req(s_close_req), .m_close_rsp(m_close_rsp),
        .port_addr(port_addr), .rsid_out(rsid_out), .route_id_out(route_id_out),
        .entry_vld_out(entry_vld_out), .init_done(init_done), .dbg_state(dbg_state)
    );

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic check_lane(input string tag, input int lane, input logic vld,
                              input logic [RB-1:0] rsid, input logic [TB-1:0] route);
        check({tag, "_vld"}, entry_vld_out[lane], vld);
        check({tag, "_rsid"}, rsid_out[lane*RB +: RB], rsid);
        check({tag, "_route"}, route_id_out[lane*TB +: TB], route);
    endtask

    task automatic listen_handshake();
        int n = 0;
        #1;
        while (s_listen_req.ready !== 1'b1 && n < 50) begin
            @(negedge aclk); #1; n++;
        end
        check("lreq_ready", s_listen_req.ready, 1'b1);
        @(negedge aclk);
        s_listen_req.valid = 1'b0;
    endtask

    task automatic send_listen(input logic [15:0] port, input logic [RB-1:0] rsid, input logic [TB-1:0] route);
        @(negedge aclk);
        s_listen_req.data  = {port, rsid, route};
        s_listen_req.valid = 1'b1;
        listen_handshake();
    endtask

    task automatic close_handshake();
        int n = 0;
        #1;
        while (s_close_req.ready !== 1'b1 && n < 50) begin
            @(negedge aclk); #1; n++;
        end
        check("creq_ready", s_close_req.ready, 1'b1);
        @(negedge aclk);
        s_close_req.valid = 1'b0;
    endtask

    task automatic send_close(input logic [15:0] port, input logic [RB-1:0] rsid);
        @(negedge aclk);
        s_close_req.data  = {port, rsid};
        s_close_req.valid = 1'b1;
        close_handshake();
    endtask

    // Called in the cycle after an accept; lat counts cycles from the accept cycle.
    task automatic wait_out(output int lat, output int which);
        lat = 1;
        which = 0;
        #1;
        while (which == 0 && lat <= 40) begin
            if (m_listen_req.valid === 1'b1) which = 1;
            else if (m_listen_rsp.valid === 1'b1) which = 2;
            else if (m_close_rsp.valid === 1'b1) which = 3;
            else begin
                @(negedge aclk); #1; lat++;
            end
        end
    endtask

    task automatic engine_reply(input logic succ, input logic [VB-1:0] vfid);
        @(negedge aclk);
        s_listen_rsp.data  = succ;
        s_listen_rsp.valid = 1'b1;
        #1;
        check("eng_ready", s_listen_rsp.ready, 1'b1);
        check("ursp_valid", m_listen_rsp.valid, 1'b1);
        check("ursp_data", m_listen_rsp.data, {vfid, succ});
        @(negedge aclk);
        s_listen_rsp.valid = 1'b0;
    endtask

    initial begin
        int lat, which;
        s_listen_req.valid = 1'b0; s_listen_req.data = '0;
        m_listen_req.ready = 1'b1;
        s_listen_rsp.valid = 1'b0; s_listen_rsp.data = '0;
        m_listen_rsp.ready = 1'b1;
        s_close_req.valid  = 1'b0; s_close_req.data = '0;
        m_close_rsp.ready  = 1'b1;
        port_addr = {4'd15, 4'd0};

        // Reset with requests pending: nothing may be acknowledged or emitted.
        s_listen_req.valid = 1'b1;
        s_close_req.valid  = 1'b1;
        s_listen_rsp.valid = 1'b1;
        repeat (3) @(negedge aclk);
        #1;
        check("rst_lreq_ready", s_listen_req.ready, 1'b0);
        check("rst_creq_ready", s_close_req.ready, 1'b0);
        check("rst_eng_ready", s_listen_rsp.ready, 1'b0);
        check("rst_fwd_valid", m_listen_req.valid, 1'b0);
        check("rst_ursp_valid", m_listen_rsp.valid, 1'b0);
        check("rst_ursp_data", m_listen_rsp.data, 0);
        check("rst_crsp_valid", m_close_rsp.valid, 1'b0);
        check("rst_init_done", init_done, 1'b0);
        @(negedge aclk);
        s_close_req.valid = 1'b0;
        aresetn = 1'b1;

        // Sweep: 16 edges after release.
        for (int k = 1; k <= 15; k++) begin
            @(negedge aclk); #1;
        end
        check("sweep_init_done", init_done, 1'b0);
        check("sweep_lreq_ready", s_listen_req.ready, 1'b0);
        check("sweep_eng_ready", s_listen_rsp.ready, 1'b0);
        s_listen_req.valid = 1'b0;
        @(negedge aclk); #1;
        check("init_done", init_done, 1'b1);
        check("late_eng_ready", s_listen_rsp.ready, 1'b0);
        s_listen_rsp.valid = 1'b0;
        repeat (2) @(negedge aclk);
        #1;
        check_lane("clr_l0", 0, 1'b0, '0, '0);
        check_lane("clr_l1", 1, 1'b0, '0, '0);
        port_addr = {4'd3, 4'd3};

        // Fresh open of 5003 with engine success.
        send_listen(16'd5003, 14'h2A5C, 14'h1234);
        wait_out(lat, which);
        check("open_which", which, 1);
        check("open_lat", lat, 4);
        check("open_port", m_listen_req.data, 16'd5003);
        engine_reply(1'b1, 4'hA);
        @(negedge aclk); #1;
        check("wr_cycle_old_vld", entry_vld_out[0], 1'b0);
        @(negedge aclk); #1;
        check_lane("open_l0", 0, 1'b1, 14'h2A5C, 14'h1234);
        check_lane("open_l1", 1, 1'b1, 14'h2A5C, 14'h1234);

        // Collision on 5003.
        send_listen(16'd5003, 14'h0C01, 14'h0055);
        wait_out(lat, which);
        check("col_which", which, 2);
        check("col_lat", lat, 4);
        check("col_data", m_listen_rsp.data, {4'h3, 1'b0});
        @(negedge aclk); #1;
        check_lane("col_l0", 0, 1'b1, 14'h2A5C, 14'h1234);

        // Out of range on both sides.
        send_listen(16'd4999, 14'h3FFF, 14'h0001);
        wait_out(lat, which);
        check("low_which", which, 2);
        check("low_lat", lat, 1);
        check("low_data", m_listen_rsp.data, {4'hF, 1'b0});
        send_listen(16'd5016, 14'h0400, 14'h0002);
        wait_out(lat, which);
        check("high_which", which, 2);
        check("high_lat", lat, 1);
        check("high_data", m_listen_rsp.data, {4'h1, 1'b0});

        // Last in-range index is forwarded.
        send_listen(16'd5015, 14'h0400, 14'h0003);
        wait_out(lat, which);
        check("top_which", which, 1);
        check("top_lat", lat, 4);
        check("top_port", m_listen_req.data, 16'd5015);
        engine_reply(1'b0, 4'h1);

        // Engine refuses 5010: no write, next attempt is forwarded again.
        send_listen(16'd5010, 14'h1800, 14'h0777);
        wait_out(lat, which);
        check("ref1_which", which, 1);
        engine_reply(1'b0, 4'h6);
        send_listen(16'd5010, 14'h1800, 14'h0777);
        wait_out(lat, which);
        check("ref2_which", which, 1);
        check("ref2_lat", lat, 4);
        check("ref2_port", m_listen_req.data, 16'd5010);
        engine_reply(1'b0, 4'h6);
        port_addr = {4'd10, 4'd3};
        repeat (3) @(negedge aclk);
        #1;
        check_lane("ref_l1", 1, 1'b0, '0, '0);

`ifdef TCP_PORT_CLOSE_EN
        // Close with wrong owner, then right owner.
        send_close(16'd5003, 14'h0C01);
        wait_out(lat, which);
        check("cbad_which", which, 3);
        check("cbad_lat", lat, 4);
        check("cbad_data", m_close_rsp.data, {16'd5003, 1'b0});
        repeat (2) @(negedge aclk);
        #1;
        check_lane("cbad_l0", 0, 1'b1, 14'h2A5C, 14'h1234);
        send_close(16'd5003, 14'h2A5C);
        wait_out(lat, which);
        check("cok_which", which, 3);
        check("cok_lat", lat, 4);
        check("cok_data", m_close_rsp.data, {16'd5003, 1'b1});
        repeat (2) @(negedge aclk);
        #1;
        check_lane("cok_l0", 0, 1'b0, '0, '0);

        // Listen and close together: listen wins.
        @(negedge aclk);
        s_listen_req.data  = {16'd4999, 14'h0800, 14'h0000};
        s_listen_req.valid = 1'b1;
        s_close_req.data   = {16'd5003, 14'h2A5C};
        s_close_req.valid  = 1'b1;
        #1;
        check("arb_lreq_ready", s_listen_req.ready, 1'b1);
        check("arb_creq_ready", s_close_req.ready, 1'b0);
        @(negedge aclk);
        s_listen_req.valid = 1'b0;
        wait_out(lat, which);
        check("arb_l_which", which, 2);
        check("arb_l_data", m_listen_rsp.data, {4'h2, 1'b0});
        check("arb_creq_wait", s_close_req.ready, 1'b0);
        @(negedge aclk);
        close_handshake();
        wait_out(lat, which);
        check("arb_c_which", which, 3);
        check("arb_c_lat", lat, 4);
        check("arb_c_data", m_close_rsp.data, {16'd5003, 1'b0});
`else
        @(negedge aclk);
        s_close_req.data  = {16'd5003, 14'h2A5C};
        s_close_req.valid = 1'b1;
        repeat (6) @(negedge aclk);
        #1;
        check("nocl_ready", s_close_req.ready, 1'b0);
        check("nocl_rsp_valid", m_close_rsp.valid, 1'b0);
        s_close_req.valid = 1'b0;
        @(negedge aclk); #1;
        check_lane("nocl_l0", 0, 1'b1, 14'h2A5C, 14'h1234);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/tcp_port_table_mc.md
# tcp_port_table_mc

Parametrised TCP listen-port table for the network stack. It sits between the user listen/close request path and the TCP offload engine's listen interface. Listen requests are range-checked and collision-checked locally before being forwarded to the engine. Successful opens are recorded as {valid, rsid, route_id} entries. The table serves N_LUP independent receive-side lookup ports, supports owner-checked port close, and self-clears after reset.

## Interface
- PORT_ORDER, 10, log2 of table depth.
- PORT_OFFS, 16'd5000, first managed TCP port; entry index = ip_port − PORT_OFFS.
- RSID_BITS, 14, session-owner id width {vfid, pid, dest}.
- ROUTE_BITS, 14, route id width.
- N_LUP, 1, number of lookup ports (1–4); each uses a replicated RAM, and writes are broadcast to all replicas.
- aclk  in  1  clock; all logic on the rising edge.
- aresetn  in  1  reset; synchronous, active-low.
- s_listen_req  metaIntf.s  —  listen request: ip_port[15:0], vfid, pid, dest, route_id.
- m_listen_req  metaIntf.m  —  forwarded request: ip_port.
- s_listen_rsp  metaIntf.s  —  engine response: open_port_success in bit 0.
- m_listen_rsp  metaIntf.m  —  user response: open_port_success, vfid.
- s_close_req  metaIntf.s  —  close request: ip_port, rsid.
- m_close_rsp  metaIntf.m  —  close response: success, ip_port.
- port_addr  in  N_LUP*PORT_ORDER  —  lookup indices, flat, lane i at [i*PORT_ORDER +: PORT_ORDER].
- rsid_out  out  N_LUP*RSID_BITS  —  looked-up owner per lane.
- route_id_out  out  N_LUP*ROUTE_BITS  —  looked-up route per lane.
- entry_vld_out  out  N_LUP  —  looked-up valid bit per lane.
- init_done  out  1  —  high once the post-reset clear sweep has finished.

## Operation
- Entry format: {vld, rsid, route_id}, width 1+RSID_BITS+ROUTE_BITS.
- ST_INIT: entered on reset.
  - Writes zero to index 0 … 2^PORT_ORDER−1, one index per cycle.
  - All s_*.ready are 0 during the sweep.
  - Goes to ST_IDLE after the last index; init_done rises in the same cycle.
- ST_IDLE arbitration: a listen request wins over a close request when both are valid. Ready is asserted for exactly one cycle on the accepted request.
- Listen path:
  - On accept, compute idx = ip_port − PORT_OFFS as 16-bit unsigned.
  - If ip_port < PORT_OFFS or idx ≥ 2^PORT_ORDER, go to ST_RSP_COL. The request is not forwarded.
  - Otherwise go ST_LUP → ST_WAIT → ST_CHECK.
  - ST_CHECK with vld=1 → ST_RSP_COL: success=0.
  - ST_CHECK with vld=0 → ST_SEND: m_listen_req.valid held until ready, then ST_RSP_WAIT.
  - ST_RSP_WAIT: s_listen_rsp.ready = m_listen_rsp.ready, and valid/success pass through.
  - On the s_listen_rsp handshake with success=1, write {1, rsid, route_id} at idx; then go to ST_IDLE.
- ST_RSP_COL: m_listen_rsp.valid=1, success=0, vfid=request vfid; holds until ready, then ST_IDLE.
- Close path (macro-gated): ST_CLOSE_LUP → ST_CLOSE_WAIT → ST_CLOSE_CHK → ST_CLOSE_RSP.
  - success=1 only if idx is in range, vld=1 and the stored rsid equals the request rsid. In that case the entry is written to zero in ST_CLOSE_CHK.
  - ST_CLOSE_RSP holds m_close_rsp.valid until ready.
- Lookup lanes are independent and always enabled. They never stall the FSM.

## Timing
- Reset values:
  - All m_*.valid = 0 and all s_*.ready = 0.
  - init_done = 0.
  - m_listen_rsp.data = 0.
  - Lookup outputs are undefined until init_done=1.
- The clear sweep takes exactly 2^PORT_ORDER cycles after aresetn rises.
- Table RAM read latency is 2 cycles, on both the control and lookup ports.
- Collision response: accept at cycle T, m_listen_rsp.valid at T+4.
- Out-of-range response: accept at T, valid at T+1.
- Forward: m_listen_req.valid at T+4.
- Table write: 1 cycle after the s_listen_rsp handshake.
  - A lookup of the same index returns the new entry 3 cycles after the handshake.
- Close response: valid at T+4.
- Lookup of an index during its write cycle returns the old value. There is no write-through.
- Reset mid-operation:
  - Any pending engine response is dropped.
  - The FSM returns to ST_INIT and re-clears the whole table.
- A late s_listen_rsp.valid outside ST_RSP_WAIT is not acknowledged (ready=0).

## Configuration
- TCP_PORT_CLOSE_EN defined: the close path and its states are present.
- TCP_PORT_CLOSE_EN not defined:
  - s_close_req.ready is tied to 0.
  - m_close_rsp.valid is tied to 0.
  - Close states are absent. Entries are cleared only by the reset sweep.

## Test plan
- Reset then idle: with PORT_ORDER=4, init_done rises exactly 16 cycles after aresetn=1, and every lookup lane reads vld=0.
- Listen 5003, engine answers success=1: m_listen_req.ip_port=5003 at T+4; m_listen_rsp success=1; lane 0 with port_addr=3 then reads vld=1 with the correct rsid and route_id.
- Second listen on 5003: no m_listen_req; m_listen_rsp success=0 at T+4; table unchanged.
- Listen 4999 and listen 5000+2^PORT_ORDER: each gives success=0 at T+1 and is never forwarded.
- Listen 5010, engine success=0: no table write; a later listen on 5010 is forwarded again.
- Close 5003 with a wrong rsid gives success=0 and the entry stays valid. Close with the correct rsid gives success=1, and lookup reads vld=0 afterwards. Simultaneous listen+close: the listen is accepted first.
